// File: rtl/trace_pkg.sv
// Shared types and entry-layout helpers for the commit trace buffer.
// Defining TRACE_TIMESTAMP_EN prepends a TS_W-bit timestamp field to each entry.
package trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2
    } state_e;

`ifdef TRACE_TIMESTAMP_EN
    localparam bit TS_FIELD_EN = 1'b1;
`else
    localparam bit TS_FIELD_EN = 1'b0;
`endif

    // Entry layout from LSB: wdata, waddr, we, inst, pc, then optional ts.
    function automatic int base_w(input int data_w, input int reg_aw);
        return 3 * data_w + reg_aw + 1;
    endfunction

    function automatic int entry_w(input int data_w, input int reg_aw, input int ts_w);
        return base_w(data_w, reg_aw) + (TS_FIELD_EN ? ts_w : 0);
    endfunction

    function automatic int pc_lsb(input int data_w, input int reg_aw);
        return 2 * data_w + reg_aw + 1;
    endfunction

endpackage

// File: rtl/trace_ram.sv
// Trace storage: one synchronous write port, one asynchronous read port.
module trace_ram #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/commit_trace_buf.sv
// Commit-trace capture unit: records retired instructions into a circular buffer
// and drains them over a valid/ready stream. TRACE_TIMESTAMP_EN adds a cycle stamp.
module commit_trace_buf
    import trace_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int DEPTH  = 64,
    parameter int TS_W   = 16,
    localparam int ENTRY_W = entry_w(DATA_W, REG_AW, TS_W),
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = AW + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               arm,
    input  logic               stop,
    input  logic               wrap_mode,
    input  logic               pc_chg_only,
    input  logic               cm_valid,
    input  logic [DATA_W-1:0]  cm_pc,
    input  logic [DATA_W-1:0]  cm_inst,
    input  logic               cm_rf_we,
    input  logic [REG_AW-1:0]  cm_rf_waddr,
    input  logic [DATA_W-1:0]  cm_rf_wdata,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic [ENTRY_W-1:0] rd_data,
    output logic               capturing,
    output logic [CW-1:0]      count,
    output logic               overflow
);

    localparam int BASE_W = base_w(DATA_W, REG_AW);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

    state_e              state_q, state_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic                overflow_q, overflow_d;
    logic                first_done_q, first_done_d;
    logic [DATA_W-1:0]   last_pc_q, last_pc_d;
    logic                rec_s, full_s, wr_en_s, pop_s, rd_valid_s;
    logic [BASE_W-1:0]   base_entry_s;
    logic [ENTRY_W-1:0]  wr_entry_s, rd_entry_s;

    assign base_entry_s = {cm_pc, cm_inst, cm_rf_we, cm_rf_waddr, cm_rf_wdata};
    assign rec_s = (state_q == ST_CAPTURE) && cm_valid &&
                   (!pc_chg_only || !first_done_q || (cm_pc != last_pc_q));
    assign full_s     = (count_q == DEPTH_C);
    assign wr_en_s    = rec_s && (!full_s || wrap_mode) && !arm;
    assign rd_valid_s = (state_q == ST_DRAIN) && (count_q != {CW{1'b0}});
    assign pop_s      = rd_valid_s && rd_ready;

`ifdef TRACE_TIMESTAMP_EN
    localparam logic [TS_W-1:0] TS_ONE = {{(TS_W-1){1'b0}}, 1'b1};
    logic [TS_W-1:0] ts_q, ts_d;

    assign wr_entry_s = {ts_q, base_entry_s};

    // Saturating capture-cycle counter, restarted by arm
    always_comb begin
        ts_d = ts_q;
        if (arm) begin
            ts_d = {TS_W{1'b0}};
        end else if ((state_q == ST_CAPTURE) && (ts_q != {TS_W{1'b1}})) begin
            ts_d = ts_q + TS_ONE;
        end else begin
            ts_d = ts_q;
        end
    end

    // Timestamp register
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q <= {TS_W{1'b0}};
        end else begin
            ts_q <= ts_d;
        end
    end
`else
    assign wr_entry_s = base_entry_s;
`endif

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en_s),
        .waddr (wr_ptr_q),
        .wdata (wr_entry_s),
        .raddr (rd_ptr_q),
        .rdata (rd_entry_s)
    );

    // FSM next state, pointer and occupancy update; arm overrides everything
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        first_done_d = first_done_q;
        last_pc_d    = last_pc_q;
        if (arm) begin
            state_d      = ST_CAPTURE;
            wr_ptr_d     = {AW{1'b0}};
            rd_ptr_d     = {AW{1'b0}};
            count_d      = {CW{1'b0}};
            overflow_d   = 1'b0;
            first_done_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_CAPTURE: begin
                    if (wr_en_s) begin
                        wr_ptr_d     = wr_ptr_q + PTR_ONE;
                        first_done_d = 1'b1;
                        last_pc_d    = cm_pc;
                    end else begin
                        wr_ptr_d = wr_ptr_q;
                    end
                    // A full buffer either loses its oldest entry or the new one
                    if (rec_s && full_s) begin
                        overflow_d = 1'b1;
                        rd_ptr_d   = wrap_mode ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
                    end else if (rec_s) begin
                        count_d = count_q + CNT_ONE;
                    end else begin
                        count_d = count_q;
                    end
                    state_d = (stop || (rec_s && !wrap_mode && (count_q >= DEPTH_C - CNT_ONE)))
                              ? ST_DRAIN : ST_CAPTURE;
                end
                ST_DRAIN: begin
                    if (pop_s) begin
                        rd_ptr_d = rd_ptr_q + PTR_ONE;
                        count_d  = count_q - CNT_ONE;
                    end else begin
                        count_d = count_q;
                    end
                    state_d = (count_d == {CW{1'b0}}) ? ST_IDLE : ST_DRAIN;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= {AW{1'b0}};
            rd_ptr_q     <= {AW{1'b0}};
            count_q      <= {CW{1'b0}};
            overflow_q   <= 1'b0;
            first_done_q <= 1'b0;
            last_pc_q    <= {DATA_W{1'b0}};
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            first_done_q <= first_done_d;
            last_pc_q    <= last_pc_d;
        end
    end

    assign rd_valid  = rd_valid_s;
    assign rd_data   = rd_valid_s ? rd_entry_s : {ENTRY_W{1'b0}};
    assign capturing = (state_q == ST_CAPTURE);
    assign count     = count_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_commit_trace_buf.sv
// Directed bench for commit_trace_buf: capture, wrap, stop-on-full, PC filter,
// stalled drain with re-arm, and timestamp fields when TRACE_TIMESTAMP_EN is set.
module tb_commit_trace_buf;

    localparam int DW     = 32;
    localparam int RA     = 5;
    localparam int DEPTH  = 64;
    localparam int TS_W   = 16;
    localparam int BASE_W = 3 * DW + RA + 1;
`ifdef TRACE_TIMESTAMP_EN
    localparam int EW = TS_W + BASE_W;
`else
    localparam int EW = BASE_W;
`endif
    localparam int CW     = $clog2(DEPTH) + 1;
    localparam int PC_LSB = 2 * DW + RA + 1;
    localparam logic [DW-1:0] BASE_PC = 32'h0040_0000;

    logic          clk = 1'b0;
    logic          rst, arm, stop, wrap_mode, pc_chg_only, cm_valid, cm_rf_we, rd_ready;
    logic [DW-1:0] cm_pc, cm_inst, cm_rf_wdata;
    logic [RA-1:0] cm_rf_waddr;
    logic          rd_valid, capturing, overflow;
    logic [EW-1:0] rd_data;
    logic [CW-1:0] count;

    int n_tests = 0;
    int n_fail  = 0;

    commit_trace_buf #(.DATA_W(DW), .REG_AW(RA), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .clk(clk), .rst(rst), .arm(arm), .stop(stop), .wrap_mode(wrap_mode),
        .pc_chg_only(pc_chg_only), .cm_valid(cm_valid), .cm_pc(cm_pc), .cm_inst(cm_inst),
        .cm_rf_we(cm_rf_we), .cm_rf_waddr(cm_rf_waddr), .cm_rf_wdata(cm_rf_wdata),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .capturing(capturing), .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BASE_W-1:0] exp_entry(input logic [DW-1:0] pc);
        return {pc, pc ^ 32'hA5A5_0000, pc[2], pc[6:2], ~pc};
    endfunction

    task automatic drive_commit(input logic [DW-1:0] pc);
        cm_valid    = 1'b1;
        cm_pc       = pc;
        cm_inst     = pc ^ 32'hA5A5_0000;
        cm_rf_we    = pc[2];
        cm_rf_waddr = pc[6:2];
        cm_rf_wdata = ~pc;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic do_stop();
        cm_valid = 1'b0;
        stop     = 1'b1;
        step();
        stop = 1'b0;
    endtask

    // Pops n entries with rd_ready held high, expecting PCs first_pc + 4*k.
    task automatic drain_check(input string tag, input logic [DW-1:0] first_pc, input int n);
        logic [DW-1:0] pc;
        rd_ready = 1'b1;
        for (int k = 0; k < n; k++) begin
            pc = first_pc + 32'(4 * k);
            check({tag, "_entry"}, 128'(rd_data[BASE_W-1:0]), 128'(exp_entry(pc)));
            check({tag, "_valid"}, 128'(rd_valid), 128'(1'b1));
            step();
        end
        rd_ready = 1'b0;
        check({tag, "_empty_cnt"}, 128'(count), 128'(0));
        check({tag, "_empty_vld"}, 128'(rd_valid), 128'(1'b0));
        check({tag, "_idle"}, 128'(capturing), 128'(1'b0));
    endtask

    initial begin
        logic [DW-1:0] filt_pcs [6];
        logic [DW-1:0] filt_exp [3];
        logic          rdy_pat [4];
        int            idx;

        rst = 1'b1; arm = 1'b0; stop = 1'b0; wrap_mode = 1'b0; pc_chg_only = 1'b0;
        cm_valid = 1'b0; cm_pc = '0; cm_inst = '0; cm_rf_we = 1'b0; cm_rf_waddr = '0;
        cm_rf_wdata = '0; rd_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("rst_count", 128'(count), 128'(0));
        check("rst_capt", 128'(capturing), 128'(1'b0));
        check("rst_valid", 128'(rd_valid), 128'(1'b0));
        check("rst_ovf", 128'(overflow), 128'(1'b0));
        check("rst_data", 128'(rd_data), 128'(0));

        // stop while idle has no effect
        do_stop();
        check("idle_stop_capt", 128'(capturing), 128'(1'b0));
        check("idle_stop_vld", 128'(rd_valid), 128'(1'b0));

        // basic capture of 10 commits
        do_arm();
        check("t1_capt", 128'(capturing), 128'(1'b1));
        for (int k = 0; k < 10; k++) begin
            drive_commit(BASE_PC + 32'(4 * k));
            step();
            check("t1_count", 128'(count), 128'(k + 1));
        end
        do_stop();
        check("t1_stop_capt", 128'(capturing), 128'(1'b0));
        check("t1_stop_cnt", 128'(count), 128'(10));
        drain_check("t1", BASE_PC, 10);
        check("t1_ovf", 128'(overflow), 128'(1'b0));

        // ring mode: 100 commits keep the newest 64
        wrap_mode = 1'b1;
        do_arm();
        for (int k = 0; k < 100; k++) begin
            drive_commit(BASE_PC + 32'(4 * k));
            step();
        end
        do_stop();
        check("t2_cnt", 128'(count), 128'(64));
        check("t2_ovf", 128'(overflow), 128'(1'b1));
        drain_check("t2", BASE_PC + 32'(4 * 36), 64);

        // stop-when-full: 64 recorded, remaining 6 ignored
        wrap_mode = 1'b0;
        do_arm();
        check("t3_ovf_clr", 128'(overflow), 128'(1'b0));
        for (int k = 0; k < 70; k++) begin
            drive_commit(BASE_PC + 32'(4 * k));
            step();
            if (k == 62) check("t3_capt_63", 128'(capturing), 128'(1'b1));
            if (k == 63) check("t3_capt_64", 128'(capturing), 128'(1'b0));
        end
        cm_valid = 1'b0;
        check("t3_cnt", 128'(count), 128'(64));
        check("t3_ovf", 128'(overflow), 128'(1'b0));
        drain_check("t3", BASE_PC, 64);

        // PC-change filter
        filt_pcs = '{32'h10, 32'h10, 32'h10, 32'h14, 32'h14, 32'h18};
        filt_exp = '{32'h10, 32'h14, 32'h18};
        pc_chg_only = 1'b1;
        do_arm();
        for (int k = 0; k < 6; k++) begin
            drive_commit(filt_pcs[k]);
            step();
        end
        do_stop();
        check("t4_cnt", 128'(count), 128'(3));
        rd_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("t4_pc", 128'(rd_data[PC_LSB +: DW]), 128'(filt_exp[k]));
            step();
        end
        rd_ready = 1'b0;
        check("t4_empty", 128'(count), 128'(0));
        pc_chg_only = 1'b0;

        // stalled drain, then arm on the third pop
        do_arm();
        for (int k = 0; k < 6; k++) begin
            drive_commit(32'h100 + 32'(4 * k));
            step();
        end
        do_stop();
        rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        idx = 0;
        for (int c = 0; c < 4; c++) begin
            rd_ready = rdy_pat[c];
            check("t5_vld", 128'(rd_valid), 128'(1'b1));
            check("t5_hold", 128'(rd_data[BASE_W-1:0]), 128'(exp_entry(32'h100 + 32'(4 * idx))));
            step();
            if (rdy_pat[c]) idx++;
        end
        check("t5_cnt", 128'(count), 128'(4));
        check("t5_pop3_pc", 128'(rd_data[PC_LSB +: DW]), 128'(32'h108));
        rd_ready = 1'b1;
        arm = 1'b1;
        step();
        arm = 1'b0;
        rd_ready = 1'b0;
        check("t5_arm_cnt", 128'(count), 128'(0));
        check("t5_arm_capt", 128'(capturing), 128'(1'b1));
        check("t5_arm_vld", 128'(rd_valid), 128'(1'b0));

        // commit coincident with stop is still recorded
        drive_commit(32'h200);
        stop = 1'b1;
        step();
        stop = 1'b0;
        cm_valid = 1'b0;
        check("t6_cnt", 128'(count), 128'(1));
        check("t6_capt", 128'(capturing), 128'(1'b0));
        check("t6_pc", 128'(rd_data[PC_LSB +: DW]), 128'(32'h200));

        // arm beats stop
        arm = 1'b1;
        stop = 1'b1;
        step();
        arm = 1'b0;
        stop = 1'b0;
        check("t7_capt", 128'(capturing), 128'(1'b1));
        check("t7_cnt", 128'(count), 128'(0));

        // reset mid-capture
        for (int k = 0; k < 3; k++) begin
            drive_commit(32'h300 + 32'(4 * k));
            step();
        end
        cm_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t8_cnt", 128'(count), 128'(0));
        check("t8_capt", 128'(capturing), 128'(1'b0));

`ifdef TRACE_TIMESTAMP_EN
        // commits at capture cycles 0, 3, 7
        do_arm();
        for (int c = 0; c < 8; c++) begin
            if (c == 0 || c == 3 || c == 7) drive_commit(32'h400 + 32'(c));
            else cm_valid = 1'b0;
            step();
        end
        do_stop();
        check("t9_cnt", 128'(count), 128'(3));
        rd_ready = 1'b1;
        check("t9_ts0", 128'(rd_data[EW-1 -: TS_W]), 128'(0));
        step();
        check("t9_ts3", 128'(rd_data[EW-1 -: TS_W]), 128'(3));
        step();
        check("t9_ts7", 128'(rd_data[EW-1 -: TS_W]), 128'(7));
        step();
        rd_ready = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/commit_trace_buf.md
# commit_trace_buf

Synthesizable commit-trace capture unit that sits beside the single-cycle CPU core and records per-instruction architectural state (PC, instruction word, register-file write) into an on-chip circular buffer. It replaces per-cycle simulation dumps with a parametrised, hardware-resident trace that works on silicon and FPGA as well as in simulation. Capture is armed and stopped by control pulses, optionally filtered to PC changes only, and drained over a valid/ready stream to a debug host or bench.

## Interface
Parameters:
- DATA_W, 32, width of PC, instruction and write-data fields
- REG_AW, 5, register-file address width
- DEPTH, 64, buffer entries; power of two, ≥ 4
- TS_W, 16, timestamp width; used only when TRACE_TIMESTAMP_EN is defined

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- arm  in  1  pulse: clear buffer, begin capture
- stop  in  1  pulse: end capture, begin drain
- wrap_mode  in  1  1 = ring (overwrite oldest), 0 = stop when full
- pc_chg_only  in  1  1 = record only if cm_pc differs from last recorded PC
- cm_valid  in  1  commit strobe, one instruction retired this cycle
- cm_pc  in  DATA_W  PC of retired instruction
- cm_inst  in  DATA_W  instruction word
- cm_rf_we  in  1  register-file write enable
- cm_rf_waddr  in  REG_AW  destination register
- cm_rf_wdata  in  DATA_W  write data
- rd_valid  out  1  rd_data holds an entry
- rd_ready  in  1  consumer accepts entry
- rd_data  out  ENTRY_W  {ts?, pc, inst, we, waddr, wdata}, ts in MSBs
- capturing  out  1  state == CAPTURE
- count  out  $clog2(DEPTH)+1  entries held
- overflow  out  1  sticky: an entry was overwritten or dropped

## Operation
- States: IDLE, CAPTURE, DRAIN. Reset → IDLE; wr_ptr, rd_ptr, count, overflow, last_pc-valid flag cleared; all outputs 0.
- IDLE: arm → CAPTURE. stop ignored.
- CAPTURE: record when cm_valid && (!pc_chg_only || !first_done || cm_pc != last_pc). Record writes mem[wr_ptr], wr_ptr++, last_pc ← cm_pc.
  - count < DEPTH: count++.
  - count == DEPTH, wrap_mode=1: overwrite oldest, rd_ptr++, count stays DEPTH, overflow ← 1.
  - wrap_mode=0: the record that makes count == DEPTH also moves state → DRAIN.
  - stop → DRAIN; a commit in the same cycle as stop is still recorded.
- DRAIN: rd_valid = (count != 0); rd_data = mem[rd_ptr] (asynchronous read). rd_valid && rd_ready → rd_ptr++, count--. Last pop → IDLE. Commits ignored.
- arm in any state (including mid-DRAIN): pointers, count, overflow, first_done cleared; state → CAPTURE; undrained entries discarded. arm and stop together: arm wins.
- Pointers are log2(DEPTH) bits and wrap naturally.
- rd_data remains stable while rd_valid && !rd_ready.

## Timing
- Capture latency: commit at edge N visible in count after edge N.
- stop at edge N: rd_valid may be 1 in cycle N+1.
- Throughput: one record per cycle in CAPTURE, one pop per cycle in DRAIN.
- rst mid-operation: immediate return to IDLE next edge; buffer contents undefined, count = 0.

## Configuration
- TRACE_TIMESTAMP_EN defined: TS_W-bit cycle counter, cleared on arm, increments every CAPTURE cycle, saturates at all-ones; its value at record time is stored in the entry MSBs; ENTRY_W = TS_W + 3·DATA_W + REG_AW + 1.
- Not defined: no counter, ENTRY_W = 3·DATA_W + REG_AW + 1.

## Structure
- Package trace_pkg: state enum, entry struct/field offsets, ENTRY_W function of parameters.
- Sub-module trace_ram: DEPTH × ENTRY_W, one synchronous write port, one asynchronous read port.
- Top holds FSM, pointers, count, filter, timestamp.

## Test plan
- Reset then arm, 10 commits PC 0x00400000+4k, stop, rd_ready=1 → 10 entries in order, count 10→0, state → IDLE, overflow=0.
- wrap_mode=1, DEPTH=64, 100 commits, stop → 64 entries, first PC = 0x00400000+4·36, overflow=1.
- wrap_mode=0, 70 commits → capturing drops after 64th, entries PC k=0..63, remaining 6 ignored, overflow=0.
- pc_chg_only=1, PCs 0x10,0x10,0x10,0x14,0x14,0x18 → 3 entries (0x10,0x14,0x18).
- Drain with rd_ready toggling 1,0,0,1 → rd_data holds during stall; no entry duplicated or skipped; arm at pop 3 → count=0, capturing=1 next cycle.
- With TRACE_TIMESTAMP_EN: arm, commits at CAPTURE cycles 0, 3, 7 → ts fields 0, 3, 7.
